// File: rtl/spi_flash_byte_ctl_if.sv
// Request/response and SPI pin bundle for one spi_flash_byte_ctl instance.
//   read, write   : one-cycle request strobes (honoured only while idle)
//   addr, din     : byte address and write data, latched on acceptance
//   dout          : last byte read, held until the next read completes
//   busy, err     : transaction in progress / write-poll timeout (sticky)
//   spi_clk/cs/mosi/miso : SPI mode-0 flash pins
// master: RAID-engine side plus the flash pin stand-in (drives miso).
// slave : the controller.
interface spi_flash_byte_ctl_if;
  logic        read;
  logic        write;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        busy;
  logic        err;
  logic        spi_clk;
  logic        spi_cs;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    output read, write, addr, din, spi_miso,
    input  dout, busy, err, spi_clk, spi_cs, spi_mosi
  );

  modport slave (
    input  read, write, addr, din, spi_miso,
    output dout, busy, err, spi_clk, spi_cs, spi_mosi
  );
endinterface

// File: rtl/spi_flash_byte_ctl.sv
// Per-drive SPI NOR byte controller. A read strobe runs one READ (0x03)
// frame; a write strobe runs WREN, PAGE PROGRAM, then RDSR polling until
// WIP clears or POLL_MAX frames have been sent.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : spi_flash_byte_ctl_if.slave (request strobes, data, status, SPI pins)
//
// state | meaning
// IDLE  | waiting for a request, cs high
// WREN  | sending write-enable frame (0x06)
// GAP1  | cs high between WREN and PAGE PROGRAM
// PROG  | READ frame (read) or PAGE PROGRAM frame (write)
// GAP2  | cs high between PAGE PROGRAM and first RDSR
// RDSR  | status poll frame: 0x05 out, status byte in
// GAP3  | cs high between RDSR polls
// DONE  | single cycle with busy low, then IDLE
module spi_flash_byte_ctl #(
  parameter int CLK_DIV  = 2,
  parameter int POLL_MAX = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_flash_byte_ctl_if.slave  bus
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_GAP   = DW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_GAP1, S_PROG, S_GAP2, S_RDSR, S_GAP3, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_mode_wr;
  logic [15:0]     r_addr;
  logic [7:0]      r_din;
  logic [39:0]     r_tx;
  logic [7:0]      r_rx;
  logic [5:0]      r_bits;
  logic [DW-1:0]   r_div;
  logic            r_sck;
  logic [PW-1:0]   r_poll;
  logic [7:0]      r_dout;
  logic            r_err;

  logic            w_idle;
  logic            w_accept;
  logic            w_in_frame;
  logic            w_in_gap;
  logic            w_frame_done;
  logic            w_gap_done;
  logic            w_wip;
  logic            w_poll_last;
  logic [15:0]     w_addr;

  assign w_idle       = (r_state == S_IDLE);
  assign w_accept     = w_idle && (bus.read || bus.write);
  assign w_in_frame   = (r_state == S_WREN) || (r_state == S_PROG) || (r_state == S_RDSR);
  assign w_in_gap     = (r_state == S_GAP1) || (r_state == S_GAP2) || (r_state == S_GAP3);
  // Last bit ends at the end of its SCK-high half.
  assign w_frame_done = w_in_frame && r_sck && (r_div == '0) && (r_bits == '0);
  assign w_gap_done   = w_in_gap && (r_div == '0);
  // Status bit0 is the last bit shifted in, so it sits in rx[0] at frame end.
  assign w_wip        = r_rx[0];
  assign w_poll_last  = (r_poll == POLL_LAST);
  // A read goes straight from IDLE to PROG before r_addr is latched.
  assign w_addr       = w_idle ? bus.addr : r_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.write)     w_next = S_WREN;
        else if (bus.read) w_next = S_PROG;
      end
      S_WREN: if (w_frame_done) w_next = S_GAP1;
      S_GAP1: if (w_gap_done)   w_next = S_PROG;
      S_PROG: if (w_frame_done) w_next = r_mode_wr ? S_GAP2 : S_DONE;
      S_GAP2: if (w_gap_done)   w_next = S_RDSR;
      S_RDSR: begin
        if (w_frame_done) w_next = (w_wip && !w_poll_last) ? S_GAP3 : S_DONE;
      end
      S_GAP3: if (w_gap_done)   w_next = S_RDSR;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode_wr <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_bits    <= '0;
      r_div     <= '0;
      r_sck     <= 1'b0;
      r_poll    <= '0;
      r_dout    <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode_wr <= bus.write;
        r_addr    <= bus.addr;
        r_din     <= bus.din;
        r_err     <= 1'b0;
        r_poll    <= '0;
      end

      if (w_next != r_state) begin
        // Every state change starts a fresh frame or gap with SCK low.
        r_sck <= 1'b0;
        r_div <= DIV_HALF;
        case (w_next)
          S_WREN: begin
            r_tx   <= {8'h06, 32'h0};
            r_bits <= 6'd7;
          end
          S_PROG: begin
            r_tx   <= w_idle ? {8'h03, 8'h00, w_addr, 8'h00}
                             : {8'h02, 8'h00, w_addr, r_din};
            r_bits <= 6'd39;
          end
          S_RDSR: begin
            r_tx   <= {8'h05, 32'h0};
            r_bits <= 6'd15;
          end
          S_GAP1, S_GAP2, S_GAP3: r_div <= DIV_GAP;
          default: ;
        endcase
      end else if (w_in_frame) begin
        if (r_div != '0) begin
          r_div <= r_div - 1'b1;
        end else if (!r_sck) begin
          r_sck <= 1'b1;
          r_rx  <= {r_rx[6:0], bus.spi_miso};
          r_div <= DIV_HALF;
        end else begin
          r_sck  <= 1'b0;
          r_tx   <= {r_tx[38:0], 1'b0};
          r_bits <= r_bits - 1'b1;
          r_div  <= DIV_HALF;
        end
      end else if (w_in_gap) begin
        r_div <= r_div - 1'b1;
      end

      if (w_frame_done && (r_state == S_PROG) && !r_mode_wr) r_dout <= r_rx;

      if (w_frame_done && (r_state == S_RDSR)) begin
        r_poll <= r_poll + 1'b1;
        if (w_wip && w_poll_last) r_err <= 1'b1;
      end
    end
  end

  assign bus.busy     = !(w_idle || (r_state == S_DONE));
  assign bus.spi_cs   = !w_in_frame;
  assign bus.spi_clk  = r_sck;
  assign bus.spi_mosi = w_in_frame & r_tx[39];
  assign bus.dout     = r_dout;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_spi_flash_byte_ctl.sv
// Bench for spi_flash_byte_ctl (CLK_DIV=2, POLL_MAX=4) with a behavioural
// SPI flash that answers READ with a chosen byte and RDSR with WIP=1 for a
// chosen number of polls.
module tb_spi_flash_byte_ctl;
  localparam int D    = 2;
  localparam int PMAX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_flash_byte_ctl_if bus ();

  spi_flash_byte_ctl #(.CLK_DIV(D), .POLL_MAX(PMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- flash model ----------------
  typedef struct {
    int          n;
    logic [39:0] v;
  } frame_t;

  frame_t      frames[$];
  int          gaps[$];
  logic [7:0]  m_rd_data = 8'h00;
  int          m_wip_polls = 0;
  int          m_poll_base = 0;
  int          m_polls = 0;
  int          m_n = 0;
  int          m_nfall = 0;
  logic [39:0] m_sh = '0;
  logic [7:0]  m_cmd = 8'h00;
  int          sck_bad = 0;
  logic        p_cs = 1'b1;
  logic        p_clk = 1'b0;
  int          gap_run = 0;

  function automatic logic resp(input logic [7:0] cmd, input int k, input logic [7:0] rd,
                                input logic wip);
    logic [7:0] b;
    b = rd;
    if (cmd == 8'h03 && k >= 32 && k < 40) return b[7-(k-32)];
    if (cmd == 8'h05 && k == 15) return wip;
    return 1'b0;
  endfunction

  assign bus.spi_miso = resp(m_cmd, m_nfall, m_rd_data, (m_polls - m_poll_base) < m_wip_polls);

  always @(bus.spi_clk or bus.spi_cs) begin
    if (p_cs === 1'b1 && bus.spi_cs === 1'b0) begin
      m_n = 0; m_nfall = 0; m_sh = '0; m_cmd = 8'h00;
    end
    if (p_clk === 1'b0 && bus.spi_clk === 1'b1) begin
      if (bus.spi_cs !== 1'b0) sck_bad++;
      m_sh = {m_sh[38:0], bus.spi_mosi};
      m_n++;
      if (m_n == 8) m_cmd = m_sh[7:0];
    end
    if (p_clk === 1'b1 && bus.spi_clk === 1'b0) m_nfall++;
    if (p_cs === 1'b0 && bus.spi_cs === 1'b1) begin
      frames.push_back('{m_n, m_sh});
      if (m_cmd == 8'h05 && m_n == 16) m_polls++;
    end
    p_cs  = bus.spi_cs;
    p_clk = bus.spi_clk;
  end

  // Length of each CS-high stretch while the controller is busy.
  always @(negedge clk) begin
    if (bus.busy === 1'b1 && bus.spi_cs === 1'b1) gap_run++;
    else if (gap_run != 0) begin
      gaps.push_back(gap_run);
      gap_run = 0;
    end
  end

  // ---------------- reference model ----------------
  function automatic int polls_for(input int wip);
    return (wip + 1 < PMAX) ? wip + 1 : PMAX;
  endfunction

  function automatic int busy_for(input bit wr, input int wip);
    int k;
    k = polls_for(wip);
    // WREN 8 bits, gap, 40-bit PP, gap, then k 16-bit polls separated by gaps.
    if (wr) return 8*2*D + 2*D + 40*2*D + 2*D + k*16*2*D + (k-1)*2*D;
    return 40*2*D;
  endfunction

  int fr_base = 0;
  int gp_base = 0;

  task automatic run_txn(input bit wr, input bit rd, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] rdat, input int wip, input bit poke,
                         output int busy_n, output logic [7:0] dout_at,
                         output logic err_at, output logic cs_at);
    @(negedge clk);
    fr_base = frames.size();
    gp_base = gaps.size();
    m_rd_data = rdat;
    m_wip_polls = wip;
    m_poll_base = m_polls;
    bus.write = wr; bus.read = rd; bus.addr = a; bus.din = d;
    @(negedge clk);
    bus.write = 1'b0; bus.read = 1'b0; bus.addr = ~a; bus.din = ~d;
    busy_n = 0;
    while (bus.busy === 1'b1 && busy_n < 3000) begin
      busy_n++;
      bus.read = (poke && busy_n == 10);
      @(negedge clk);
    end
    bus.read = 1'b0;
    dout_at = bus.dout;
    err_at  = bus.err;
    cs_at   = bus.spi_cs;
    @(negedge clk);
  endtask

  task automatic check_txn(input string tag, input bit wr, input logic [15:0] a,
                           input logic [7:0] d, input int wip,
                           input int busy_n, input int exp_busy,
                           input logic [7:0] dout_at, input logic [7:0] exp_dout,
                           input logic err_at, input logic exp_err, input logic cs_at);
    frame_t ef[$];
    int ng;
    if (wr) begin
      ef.push_back('{8, 40'h06});
      ef.push_back('{40, {8'h02, 8'h00, a, d}});
      for (int i = 0; i < polls_for(wip); i++) ef.push_back('{16, 40'h0500});
      ng = polls_for(wip) + 1;
    end else begin
      ef.push_back('{40, {8'h03, 8'h00, a, 8'h00}});
      ng = 0;
    end
    chk({tag, " busy_len"}, busy_n, exp_busy);
    chk({tag, " dout"}, dout_at, exp_dout);
    chk({tag, " err"}, err_at, exp_err);
    chk({tag, " cs_done"}, cs_at, 1'b1);
    chk({tag, " nframes"}, frames.size() - fr_base, ef.size());
    for (int i = 0; i < ef.size(); i++) begin
      if (fr_base + i < frames.size()) begin
        chk($sformatf("%s frame%0d bits", tag, i), frames[fr_base+i].n, ef[i].n);
        chk($sformatf("%s frame%0d data", tag, i), frames[fr_base+i].v, ef[i].v);
      end
    end
    chk({tag, " ngaps"}, gaps.size() - gp_base, ng);
    for (int i = gp_base; i < gaps.size(); i++)
      chk($sformatf("%s gap%0d len", tag, i - gp_base), gaps[i], 2*D);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " busy"}, bus.busy, 1'b0);
    chk({tag, " cs"}, bus.spi_cs, 1'b1);
    chk({tag, " sck"}, bus.spi_clk, 1'b0);
    chk({tag, " mosi"}, bus.spi_mosi, 1'b0);
    chk({tag, " dout"}, bus.dout, 8'h00);
    chk({tag, " err"}, bus.err, 1'b0);
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [7:0]  rdat;
    int          wip;
    bit          poke;
    int          exp_busy;
    logic [7:0]  exp_dout;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t        tbl[6];
    int          busy_n;
    logic [7:0]  dout_at;
    logic        err_at;
    logic        cs_at;
    logic [7:0]  mdl_dout;
    int          nf;

    //            wr    rd    addr      din    rdat   wip poke busy dout   err
    tbl[0] = '{1'b0, 1'b1, 16'h1234, 8'h00, 8'hA5, 0, 1'b0, 160, 8'hA5, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h00FF, 8'h5A, 8'h00, 3, 1'b0, 468, 8'hA5, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 16'hBEEF, 8'h00, 8'h00, 0, 1'b0, 264, 8'hA5, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'h0102, 8'hC3, 8'h00, 9, 1'b0, 468, 8'hA5, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 16'h0001, 8'h00, 8'h3C, 0, 1'b0, 160, 8'h3C, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'h4000, 8'h81, 8'hEE, 1, 1'b1, 332, 8'h3C, 1'b0};

    reset = 1'b1;
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.din = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset_init");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].din, tbl[i].rdat, tbl[i].wip,
              tbl[i].poke, busy_n, dout_at, err_at, cs_at);
      check_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].wip,
                busy_n, tbl[i].exp_busy, dout_at, tbl[i].exp_dout, err_at, tbl[i].exp_err, cs_at);
      nf = frames.size();
      repeat (20) @(negedge clk);
      chk($sformatf("vec%0d idle_busy", i), bus.busy, 1'b0);
      chk($sformatf("vec%0d no_extra_frame", i), frames.size() - nf, 0);
    end

    // Reset asserted during bit 19 of a read frame (cycles 77..80).
    @(negedge clk);
    m_rd_data = 8'hA5; m_wip_polls = 0; m_poll_base = m_polls;
    bus.read = 1'b1; bus.addr = 16'h1234;
    @(negedge clk);
    bus.read = 1'b0;
    repeat (77) @(negedge clk);
    chk("rst_mid busy_before", bus.busy, 1'b1);
    chk("rst_mid cs_before", bus.spi_cs, 1'b0);
    #1 reset = 1'b1;
    #1 check_reset_state("rst_mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid stays_idle", bus.busy, 1'b0);
    run_txn(1'b0, 1'b1, 16'h0001, 8'h00, 8'h77, 0, 1'b0, busy_n, dout_at, err_at, cs_at);
    check_txn("post_rst", 1'b0, 16'h0001, 8'h00, 0, busy_n, 160, dout_at, 8'h77,
              err_at, 1'b0, cs_at);
    mdl_dout = 8'h77;

    // Randomized transactions against the reference model.
    for (int i = 0; i < 8; i++) begin
      bit          wr, rd, pk;
      logic [15:0] a;
      logic [7:0]  d, rdat;
      int          wip;
      wr   = 1'($urandom_range(0, 1));
      rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      pk   = 1'($urandom_range(0, 1));
      a    = 16'($urandom);
      d    = 8'($urandom);
      rdat = 8'($urandom);
      wip  = int'($urandom_range(0, 5));
      run_txn(wr, rd, a, d, rdat, wip, pk, busy_n, dout_at, err_at, cs_at);
      if (!wr) mdl_dout = rdat;
      check_txn($sformatf("rnd%0d", i), wr, a, d, wip, busy_n, busy_for(wr, wip),
                dout_at, mdl_dout, err_at, wr && (wip >= PMAX), cs_at);
    end

    chk("sck_while_cs_high", sck_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
